// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
//   Request/response bundle between the pipeline's MEM stage (master) and the
//   data-memory responder (slave).
//
//   req_valid  master->slave  request present
//   req_write  master->slave  1 = store, 0 = load
//   req_addr   master->slave  byte address
//   req_wdata  master->slave  store data
//   req_ready  slave->master  responder can accept this cycle
//   rsp_valid  slave->master  one-cycle completion pulse
//   rsp_rdata  slave->master  load data (0 when rsp_valid=0)
//   rsp_err    slave->master  illegal request flag (0 when rsp_valid=0)
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Word-addressed data memory with a programmable number of wait states.
//   One request outstanding at a time: accept in IDLE, count down in WAIT,
//   pulse the response in RESP. Words are stored whole; big-endian byte order
//   means byte address 4*i maps to bits [31:24] of word i.
//
//   Parameters
//     DEPTH_WORDS  number of 32-bit words (legal word index 0..DEPTH_WORDS-1)
//     WAIT_CYCLES  wait states between acceptance and response (0..15)
//
//   Ports
//     clk  clock, all state changes on the rising edge
//     rst  synchronous active-high reset
//     bus  slave side of dmem_responder_if
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);

  localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_commit;
  logic        w_c_write;
  logic [31:0] w_c_addr;
  logic [31:0] w_c_wdata;
  logic        w_legal;
  logic [IDX_W-1:0] w_idx;

  // Commit source: with zero wait states the commit happens on the acceptance
  // edge itself, so the live bus fields are used instead of the latched copy.
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_accept  = bus.req_valid && (r_state == S_IDLE);
    w_commit  = 1'b0;
    w_c_write = r_write;
    w_c_addr  = r_addr;
    w_c_wdata = r_wdata;
    if (w_accept && (WAIT_CYCLES == 0)) begin
      w_commit  = 1'b1;
      w_c_write = bus.req_write;
      w_c_addr  = bus.req_addr;
      w_c_wdata = bus.req_wdata;
    end else if ((r_state == S_WAIT) && (r_cnt == 4'd1)) begin
      w_commit  = 1'b1;
    end
  end

  assign w_legal = (w_c_addr[1:0] == 2'b00) && (w_c_addr[31:2] < DEPTH_L);
  assign w_idx   = w_c_addr[IDX_W+1:2];

  // Next state and outputs.
  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (w_accept) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) w_next = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = r_rdata;
        bus.rsp_err   = r_err;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the storage array is cleared on reset because loads after reset must
  // return zero; this forces the array into flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_addr;
        r_wdata <= bus.req_wdata;
        r_cnt   <= WAIT_L;
      end else if (r_state == S_WAIT) begin
        r_cnt   <= r_cnt - 4'd1;
      end

      if (w_commit) begin
        if (w_legal) begin
          r_err <= 1'b0;
          if (w_c_write) begin
            r_mem[w_idx] <= w_c_wdata;
            r_rdata      <= '0;
          end else begin
            r_rdata      <= r_mem[w_idx];
          end
        end else begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
    end
  end

endmodule
